reexe_stage: RTL and testbench

//  REEXE pipeline stage, directly downstream of the PREMEM branch-amend stage.
//  - Accepts one instruction per handshake from the upstream stage.
//  - For non-blocking mul/div instructions, holds the entry until the MDU returns its result.
//  - Forwards the stage result to issue/bypass and presents a registered payload to WB.
//  - A CP0 exception flush empties the stage and cancels any MDU wait in progress.

---
 rtl/reexe_pkg.sv | 18 +
 rtl/reexe_stage.sv | 122 ++++++++++++
 tb/tb_reexe_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reexe_pkg.sv
// Shared widths, forward-mode codes and REEXE state encoding for the REEXE stage.
package reexe_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int GPR_NUM     = 5;
    localparam int EXCCODE     = 5;
    localparam int FORWARD_MODE = 2;

    localparam logic [FORWARD_MODE-1:0] FORWARD_MODE_WAIT  = 2'd0;
    localparam logic [FORWARD_MODE-1:0] FORWARD_MODE_REEXE = 2'd1;

    typedef enum logic [1:0] {
        REEXE_EMPTY    = 2'd0,
        REEXE_WAIT_MDU = 2'd1,
        REEXE_HOLD     = 2'd2
    } reexe_state_t;

endpackage

// File: rtl/reexe_stage.sv
// REEXE stage: holds one instruction, parks mul/div entries until the MDU answers,
// then presents a registered payload to WB and a bypass view to issue.
module reexe_stage
    import reexe_pkg::*;
#(
    parameter int DATA_W = SINGLE_WORD,
    parameter int REG_W  = GPR_NUM,
    parameter int EXC_W  = EXCCODE,
    parameter int FWD_W  = FORWARD_MODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CP0_excOccur_w_i,
    input  logic              SBA_valid_w_i,
    output logic              REEXE_allowin_w_o,
    input  logic              WB_allowin_w_i,
    output logic              REEXE_valid_w_o,
    input  logic [REG_W-1:0]  SBA_writeNum_i,
    input  logic [DATA_W-1:0] SBA_VAddr_i,
    input  logic [DATA_W-1:0] SBA_aluRes_i,
    input  logic              SBA_nonBlockMark_i,
    input  logic              SBA_hasException_i,
    input  logic [EXC_W-1:0]  SBA_ExcCode_i,
    input  logic              MDU_resultValid_w_i,
    input  logic [DATA_W-1:0] MDU_result_w_i,
    output logic              MDU_cancel_w_o,
    output logic [DATA_W-1:0] REEXE_forwardData_w_o,
    output logic [FWD_W-1:0]  REEXE_forwardMode_w_o,
    output logic [REG_W-1:0]  REEXE_writeNum_w_o,
    output logic [REG_W-1:0]  REEXE_writeNum_o,
    output logic [DATA_W-1:0] REEXE_VAddr_o,
    output logic [DATA_W-1:0] REEXE_wbData_o,
    output logic              REEXE_hasException_o,
    output logic [EXC_W-1:0]  REEXE_ExcCode_o
);

    reexe_state_t state, state_nxt;

    logic [REG_W-1:0]  write_num;
    logic [DATA_W-1:0] vaddr;
    logic [DATA_W-1:0] wb_data;
    logic              has_exc;
    logic [EXC_W-1:0]  exc_code;

    logic allowin, accept, load, clear, mdu_load;

    always_comb begin
        allowin   = (state == REEXE_EMPTY) || ((state == REEXE_HOLD) && WB_allowin_w_i);
        accept    = allowin && SBA_valid_w_i && !CP0_excOccur_w_i;
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        mdu_load  = 1'b0;
        // Flush wins over everything, including a same-cycle MDU strobe.
        if (CP0_excOccur_w_i) begin
            state_nxt = REEXE_EMPTY;
            clear     = 1'b1;
        end else if (accept) begin
            load      = 1'b1;
            state_nxt = (SBA_nonBlockMark_i && !SBA_hasException_i) ? REEXE_WAIT_MDU : REEXE_HOLD;
        end else begin
            case (state)
                REEXE_HOLD: begin
                    if (WB_allowin_w_i) begin
                        state_nxt = REEXE_EMPTY;
                        clear     = 1'b1;
                    end
                end
                REEXE_WAIT_MDU: begin
                    if (MDU_resultValid_w_i) begin
                        state_nxt = REEXE_HOLD;
                        mdu_load  = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REEXE_EMPTY;
            write_num <= '0;
            vaddr     <= '0;
            wb_data   <= '0;
            has_exc   <= 1'b0;
            exc_code  <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                write_num <= '0;
                vaddr     <= '0;
                wb_data   <= '0;
                has_exc   <= 1'b0;
                exc_code  <= '0;
            end else if (load) begin
                write_num <= SBA_writeNum_i;
                vaddr     <= SBA_VAddr_i;
                wb_data   <= SBA_aluRes_i;
                has_exc   <= SBA_hasException_i;
                exc_code  <= SBA_ExcCode_i;
            end else if (mdu_load) begin
                wb_data   <= MDU_result_w_i;
            end
        end
    end

    assign REEXE_allowin_w_o     = allowin;
    assign REEXE_valid_w_o       = (state == REEXE_HOLD);
    assign MDU_cancel_w_o        = CP0_excOccur_w_i && (state == REEXE_WAIT_MDU);
    assign REEXE_forwardData_w_o = wb_data;
    // An excepted instruction must never reach the register file via bypass.
    assign REEXE_writeNum_w_o    = ((state != REEXE_EMPTY) && !has_exc) ? write_num : '0;
    assign REEXE_forwardMode_w_o = ((state == REEXE_HOLD) && (write_num != '0))
                                   ? FWD_W'(FORWARD_MODE_REEXE) : FWD_W'(FORWARD_MODE_WAIT);
    assign REEXE_writeNum_o      = write_num;
    assign REEXE_VAddr_o         = vaddr;
    assign REEXE_wbData_o        = wb_data;
    assign REEXE_hasException_o  = has_exc;
    assign REEXE_ExcCode_o       = exc_code;

endmodule

// File: tb/tb_reexe_stage.sv
// Scoreboard bench for reexe_stage: directed scenarios, then random traffic, then async reset mid-wait.
module tb_reexe_stage;
    import reexe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, sba_valid, wb_allowin, nb, exc, mdu_valid;
    logic [4:0]  wn, code;
    logic [31:0] va, alu, mdu_res;

    logic        allowin, valid, cancel;
    logic [31:0] fwd_data, o_va, o_wb;
    logic [1:0]  fwd_mode;
    logic [4:0]  fwd_wn, o_wn, o_code;
    logic        o_exc;

    reexe_stage dut (
        .clk(clk), .rst(rst),
        .CP0_excOccur_w_i(flush), .SBA_valid_w_i(sba_valid), .REEXE_allowin_w_o(allowin),
        .WB_allowin_w_i(wb_allowin), .REEXE_valid_w_o(valid),
        .SBA_writeNum_i(wn), .SBA_VAddr_i(va), .SBA_aluRes_i(alu),
        .SBA_nonBlockMark_i(nb), .SBA_hasException_i(exc), .SBA_ExcCode_i(code),
        .MDU_resultValid_w_i(mdu_valid), .MDU_result_w_i(mdu_res), .MDU_cancel_w_o(cancel),
        .REEXE_forwardData_w_o(fwd_data), .REEXE_forwardMode_w_o(fwd_mode),
        .REEXE_writeNum_w_o(fwd_wn), .REEXE_writeNum_o(o_wn), .REEXE_VAddr_o(o_va),
        .REEXE_wbData_o(o_wb), .REEXE_hasException_o(o_exc), .REEXE_ExcCode_o(o_code)
    );

    always #5 clk = ~clk;

    // One entry in flight: what WB should eventually see, and whether it still awaits the MDU.
    typedef struct {
        logic [4:0]  wn;
        logic [31:0] va;
        logic [31:0] wb;
        logic        exc;
        logic [4:0]  code;
        logic        wt;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    bit   p_flush, p_strobe, p_acc;
    ent_t p_ent;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Decide, from the current model and inputs, what the coming clock edge does.
    task automatic plan();
        bit occ, allow;
        occ      = (q.size() != 0);
        allow    = !occ || (!q[0].wt && wb_allowin);
        p_flush  = flush;
        p_strobe = occ && q[0].wt && mdu_valid;
        p_acc    = allow && sba_valid && !flush;
        p_ent.wn   = wn;
        p_ent.va   = va;
        p_ent.wb   = alu;
        p_ent.exc  = exc;
        p_ent.code = code;
        p_ent.wt   = nb && !exc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (p_flush) begin
            q.delete();
        end else begin
            if (p_strobe) begin
                q[0].wb = mdu_res;
                q[0].wt = 1'b0;
            end
            if (p_acc) q.push_back(p_ent);
        end
        check("occupancy", 64'(q.size() <= 1), 64'(1));
    endtask

    task automatic cyc(input logic sv, input logic [4:0] w, input logic [31:0] a, input logic [31:0] r,
                       input logic n, input logic e, input logic [4:0] c, input logic wa,
                       input logic f, input logic mv, input logic [31:0] mr);
        sba_valid = sv; wn = w; va = a; alu = r; nb = n; exc = e; code = c;
        wb_allowin = wa; flush = f; mdu_valid = mv; mdu_res = mr;
        plan();
        step();
    endtask

    task automatic idle(input logic wa);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, wa, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: compare DUT against the model; a WB handshake retires the head entry.
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            bit   occ, vld;
            occ = (q.size() != 0);
            if (occ) e = q[0];
            else begin
                e.wn = '0; e.va = '0; e.wb = '0; e.exc = 1'b0; e.code = '0; e.wt = 1'b0;
            end
            vld = occ && !e.wt;
            check("valid",    64'(valid),   64'(vld));
            check("allowin",  64'(allowin), 64'(!occ || (vld && wb_allowin)));
            check("cancel",   64'(cancel),  64'(flush && occ && e.wt));
            check("fwd_wn",   64'(fwd_wn),  64'((occ && !e.exc) ? e.wn : 5'd0));
            check("fwd_mode", 64'(fwd_mode),
                  64'((vld && e.wn != 0) ? FORWARD_MODE_REEXE : FORWARD_MODE_WAIT));
            check("fwd_data", 64'(fwd_data), 64'(e.wb));
            check("wb_wn",    64'(o_wn),     64'(e.wn));
            check("wb_va",    64'(o_va),     64'(e.va));
            check("wb_data",  64'(o_wb),     64'(e.wb));
            check("wb_exc",   64'(o_exc),    64'(e.exc));
            check("wb_code",  64'(o_code),   64'(e.code));
            if (vld && wb_allowin) void'(q.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        flush = 0; sba_valid = 0; wb_allowin = 0; nb = 0; exc = 0; mdu_valid = 0;
        wn = 0; code = 0; va = 0; alu = 0; mdu_res = 0;
        p_flush = 0; p_strobe = 0; p_acc = 0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ALU op, then a back-to-back second op, then drain.
        cyc(1'b1, 5'd3, 32'h100, 32'h1234, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 5'd4, 32'h104, 32'h5678, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Non-blocking op waits for the MDU, then holds its result.
        cyc(1'b1, 5'd8, 32'h200, 32'hDEAD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) idle(1'b1);
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'hCAFE);
        idle(1'b0);
        idle(1'b1);

        // Flush during the wait, with a same-cycle MDU strobe.
        cyc(1'b1, 5'd9, 32'h300, 32'h1111, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1'b1);
        cyc(1'b1, 5'd2, 32'h304, 32'h2222, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hBEEF);
        idle(1'b1);

        // WB stalls for 3 cycles while a new entry is waiting upstream.
        cyc(1'b1, 5'd5, 32'h400, 32'h5555, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) cyc(1'b1, 5'd6, 32'h404, 32'h6666, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 5'd6, 32'h404, 32'h6666, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1'b1);

        // Excepted non-blocking op skips the MDU wait.
        cyc(1'b1, 5'd7, 32'h500, 32'h7777, 1'b1, 1'b1, 5'h0C, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(1'b0);
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 3) != 0, 5'($urandom), $urandom, $urandom,
                ($urandom % 3) == 0, ($urandom % 6) == 0, 5'($urandom),
                ($urandom % 4) != 0, ($urandom % 30) == 0, ($urandom % 4) == 0, $urandom);
        end

        // Async reset in the middle of an MDU wait.
        cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 5'd10, 32'h600, 32'hABCD, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        sba_valid = 1'b0; mdu_valid = 1'b0; flush = 1'b0;
        plan();
        #2 chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_allowin", 64'(allowin), 64'(1));
        check("rst_valid",   64'(valid),   64'(0));
        check("rst_cancel",  64'(cancel),  64'(0));
        check("rst_fwd_wn",  64'(fwd_wn),  64'(0));
        check("rst_mode",    64'(fwd_mode), 64'(FORWARD_MODE_WAIT));
        check("rst_payload", {o_wb, 27'(o_va), o_wn}, 64'(0));
        check("rst_misc",    64'({fwd_data, o_va[31:27], o_exc, o_code}), 64'(0));
        q.delete();
        p_flush = 0; p_strobe = 0; p_acc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        cyc(1'b1, 5'd11, 32'h700, 32'h9999, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
